// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD engine.
// Holds the FSM state encoding and the saturating counter step.
package gcd_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ZERO_CHK,
    REDUCE,
    LOOP,
    SCALE,
    DONE
  } state_e;

  // Increment that sticks at 2**width-1; width must stay below 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/gcd_binary_hs.sv
// Binary (Stein) GCD engine: one iteration per clock, valid/ready on both sides.
// Result, coprime flag and cycle count hold until the next DONE.
//
//   state    | meaning
//   IDLE     | ready for a new operand pair
//   ZERO_CHK | short-circuit when either operand is zero
//   REDUCE   | strip common factors of two, counting them in k
//   LOOP     | Stein iteration until x == y
//   SCALE    | restore common factor: res = x << k
//   DONE     | result presented until the sink takes it
module gcd_binary_hs
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CYC_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_gcd_o,
  output logic             out_coprime_o,
  output logic [CYC_W-1:0] out_cycles_o
);

  localparam int unsigned KW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic             cop_q, cop_d;

  logic             x_even, y_even, any_zero;
  logic [WIDTH-1:0] diff_xy, diff_yx, scaled, zero_res;
  logic [CYC_W-1:0] cnt_inc;

  assign x_even   = ~x_q[0];
  assign y_even   = ~y_q[0];
  assign any_zero = (x_q == '0) || (y_q == '0);
  assign diff_xy  = x_q - y_q;
  assign diff_yx  = y_q - x_q;
  assign scaled   = x_q << k_q;
  assign zero_res = x_q | y_q;
  assign cnt_inc  = CYC_W'(sat_inc(32'(cnt_q), CYC_W));

  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign out_gcd_o     = res_q;
  assign out_coprime_o = cop_q;
  assign out_cycles_o  = cyc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_valid_i) state_d = ZERO_CHK;
      ZERO_CHK: state_d = any_zero ? DONE : REDUCE;
      REDUCE:   if (!(x_even && y_even)) state_d = LOOP;
      LOOP:     if (x_q == y_q) state_d = SCALE;
      SCALE:    state_d = DONE;
      DONE:     if (out_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    k_d   = k_q;
    cnt_d = cnt_q;
    res_d = res_q;
    cop_d = cop_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          x_d   = in_a_i;
          y_d   = in_b_i;
          k_d   = '0;
          cnt_d = '0;
        end
      end
      ZERO_CHK: begin
        if (any_zero) begin
          res_d = zero_res;
          cop_d = (zero_res == WIDTH'(1));
          cyc_d = cnt_q;
        end
      end
      REDUCE: begin
        cnt_d = cnt_inc;
        if (x_even && y_even) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end
      end
      LOOP: begin
        cnt_d = cnt_inc;
        // Both operands odd in the subtract branches, so the difference is even.
        if (x_q != y_q) begin
          if (x_even)          x_d = x_q >> 1;
          else if (y_even)     y_d = y_q >> 1;
          else if (x_q > y_q)  x_d = diff_xy >> 1;
          else                 y_d = diff_yx >> 1;
        end
      end
      SCALE: begin
        cnt_d = cnt_inc;
        res_d = scaled;
        cop_d = (scaled == WIDTH'(1));
        cyc_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
      cop_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      cop_q <= cop_d;
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: tb/tb_gcd_binary_hs.sv
// Scoreboard bench for gcd_binary_hs: an 8-bit instance for directed cases and
// a 16-bit instance checked against a Euclid reference on random pairs.
module tb_gcd_binary_hs;

  typedef struct {
    logic [15:0] gcd;
    logic [6:0]  cyc;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb8[$];
  exp_t sb16[$];

  logic       rst8 = 1'b1, v8 = 1'b0, ordy8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       rdy8, ov8, cp8;
  logic [7:0] g8;
  logic [5:0] cy8;

  logic        rst16 = 1'b1, v16 = 1'b0, ordy16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, ov16, cp16;
  logic [15:0] g16;
  logic [6:0]  cy16;

  gcd_binary_hs #(.WIDTH(8), .CYC_W(6)) u_dut8 (
    .clk_i(clk), .rst_i(rst8), .in_valid_i(v8), .in_ready_o(rdy8),
    .in_a_i(a8), .in_b_i(b8), .out_valid_o(ov8), .out_ready_i(ordy8),
    .out_gcd_o(g8), .out_coprime_o(cp8), .out_cycles_o(cy8)
  );

  gcd_binary_hs #(.WIDTH(16), .CYC_W(7)) u_dut16 (
    .clk_i(clk), .rst_i(rst16), .in_valid_i(v16), .in_ready_o(rdy16),
    .in_a_i(a16), .in_b_i(b16), .out_valid_o(ov16), .out_ready_i(ordy16),
    .out_gcd_o(g16), .out_coprime_o(cp16), .out_cycles_o(cy16)
  );

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Returns #1 after the accept edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                       input logic [6:0] cyc, input bit chk, input bit push);
    int t = 0;
    while (!rdy8 && t < 100) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!rdy8) begin n_fail++; $display("FAIL in_ready_timeout8: in_ready=%b required 1", rdy8); end
    a8 = a; b8 = b; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    if (push) sb8.push_back('{gcd: {8'd0, g}, cyc: cyc, chk: chk});
  endtask

  task automatic recv8(input int hold, input bit pulse);
    exp_t e;
    logic [7:0] g0;
    logic [5:0] c0;
    int t = 0;
    while (!ov8 && t < 200) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!ov8) begin n_fail++; $display("FAIL out_valid_timeout8: out_valid=%b required 1", ov8); return; end
    n_checks++;
    if (sb8.size() == 0) begin n_fail++; $display("FAIL unexpected_result8: got gcd=%0d, none expected", g8); return; end
    e = sb8.pop_front();
    n_checks++;
    if (g8 !== e.gcd[7:0]) begin n_fail++; $display("FAIL gcd8: got %0d required %0d", g8, e.gcd[7:0]); end
    n_checks++;
    if (cp8 !== (e.gcd == 16'd1)) begin n_fail++; $display("FAIL coprime8: got %b required %b", cp8, e.gcd == 16'd1); end
    if (e.chk) begin
      n_checks++;
      if (cy8 !== e.cyc[5:0]) begin n_fail++; $display("FAIL cycles8: got %0d required %0d", cy8, e.cyc[5:0]); end
    end
    g0 = g8; c0 = cy8;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin a8 = 8'd9; b8 = 8'd3; v8 = (i % 2 == 0); end
      @(posedge clk); #1;
      n_checks++;
      if (ov8 !== 1'b1 || g8 !== g0 || cy8 !== c0 || rdy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable8 cycle %0d: valid=%b gcd=%0d cyc=%0d in_ready=%b required 1/%0d/%0d/0",
                 i, ov8, g8, cy8, rdy8, g0, c0);
      end
    end
    v8 = 1'b0;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake8: out_valid=%b in_ready=%b required 0/1", ov8, rdy8);
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g);
    int t = 0;
    while (!rdy16 && t < 100) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!rdy16) begin n_fail++; $display("FAIL in_ready_timeout16: in_ready=%b required 1", rdy16); end
    a16 = a; b16 = b; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    sb16.push_back('{gcd: g, cyc: 7'd0, chk: 1'b0});
  endtask

  task automatic recv16();
    exp_t e;
    int t = 0;
    while (!ov16 && t < 200) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!ov16) begin n_fail++; $display("FAIL out_valid_timeout16: out_valid=%b required 1", ov16); return; end
    n_checks++;
    if (sb16.size() == 0) begin n_fail++; $display("FAIL unexpected_result16: got gcd=%0d", g16); return; end
    e = sb16.pop_front();
    n_checks++;
    if (g16 !== e.gcd || cp16 !== (e.gcd == 16'd1)) begin
      n_fail++;
      $display("FAIL gcd16: got %0d/coprime %b required %0d/%b", g16, cp16, e.gcd, e.gcd == 16'd1);
    end
    n_checks++;
    if (cy16 > 7'd48) begin n_fail++; $display("FAIL cycles16_bound: got %0d required <= 48", cy16); end
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0; rst16 = 1'b0;
    n_checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || g8 !== 8'd0 || cp8 !== 1'b0 || cy8 !== 6'd0) begin
      n_fail++;
      $display("FAIL reset8: rdy=%b ov=%b gcd=%0d cp=%b cyc=%0d required 1/0/0/0/0", rdy8, ov8, g8, cp8, cy8);
    end
    n_checks++;
    if (rdy16 !== 1'b1 || ov16 !== 1'b0 || g16 !== 16'd0 || cp16 !== 1'b0 || cy16 !== 7'd0) begin
      n_fail++;
      $display("FAIL reset16: rdy=%b ov=%b gcd=%0d cp=%b cyc=%0d required 1/0/0/0/0", rdy16, ov16, g16, cp16, cy16);
    end
  endtask

  // Cycle counts worked by hand from the Stein step sequence.
  task automatic test_basic();
    send8(8'd48,  8'd18,  8'd6,   7'd8,  1'b1, 1'b1); recv8(0, 1'b0);
    send8(8'd17,  8'd5,   8'd1,   7'd7,  1'b1, 1'b1); recv8(0, 1'b0);
    send8(8'd255, 8'd255, 8'd255, 7'd3,  1'b1, 1'b1); recv8(0, 1'b0);
    send8(8'd128, 8'd64,  8'd64,  7'd10, 1'b1, 1'b1); recv8(0, 1'b0);
  endtask

  task automatic test_zero();
    send8(8'd0, 8'd36, 8'd36, 7'd0, 1'b1, 1'b1);
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL zero_early: out_valid=%b required 0", ov8); end
    @(posedge clk); #1;
    n_checks++;
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL zero_latency: out_valid=%b required 1", ov8); end
    recv8(0, 1'b0);
    send8(8'd0, 8'd0, 8'd0, 7'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL zero0_latency: out_valid=%b required 1", ov8); end
    recv8(0, 1'b0);
  endtask

  task automatic test_backpressure();
    send8(8'd48, 8'd18, 8'd6, 7'd8, 1'b1, 1'b1);
    recv8(5, 1'b1);
    send8(8'd12, 8'd8, 8'd4, 7'd7, 1'b1, 1'b1);
    recv8(0, 1'b0);
    n_checks++;
    if (sb8.size() != 0) begin n_fail++; $display("FAIL sb8_leftover: got %0d entries required 0", sb8.size()); end
  endtask

  task automatic test_reset_midop();
    bit seen = 1'b0;
    send8(8'd200, 8'd150, 8'd50, 7'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    n_checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || g8 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_midop: rdy=%b ov=%b gcd=%0d required 1/0/0", rdy8, ov8, g8);
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_midop_output: out_valid rose=%b required 0", seen); end
  endtask

  task automatic test_w16();
    logic [15:0] a, b, c;
    send16(16'd65535, 16'd255, 16'd255);
    recv16();
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) begin
        c = 16'($urandom_range(1, 255));
        a = c * 16'($urandom_range(0, 255));
        b = c * 16'($urandom_range(0, 255));
      end else begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
      end
      send16(a, b, ref_gcd(a, b));
      recv16();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_reset_midop();
    test_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
